seq_div_restoring: RTL and testbench

Sequential unsigned radix-2 restoring divider, the inverse-operation companion to the multiplier datapath blocks. It resolves one quotient bit per cycle with a WIDTH+1-bit ripple subtract (a + ~b + 1) of the same carry-propagate style as the multiplier's final adder. Operands enter and results leave through valid/ready handshakes, so the block sits between an operand source and a result consumer in the arithmetic unit.

---
 rtl/seq_div_restoring.sv | 119 +++++++++++
 tb/tb_seq_div_restoring.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div_restoring.sv
`default_nettype none
// ============================================================================
// Module   : seq_div_restoring
// Brief    : Sequential unsigned radix-2 restoring divider with valid/ready
//            operand and result handshakes, one quotient bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module seq_div_restoring #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [WIDTH:0] c_ONE = {{WIDTH{1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   w_s;
    logic [WIDTH:0]   w_t;
    logic             w_borrow;

    // The partial remainder's top bit is always zero between iterations
    // (R < D), so only WIDTH bits of R are stored.
    assign w_s      = {rem_q, quo_q[WIDTH-1]};
    assign w_t      = w_s + ~{1'b0, dvs_q} + c_ONE;
    assign w_borrow = w_t[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (in_valid) state_d = c_BUSY;
            c_BUSY:  if (dbz_q || (cnt_q == CNT_W'(1))) state_d = c_DONE;
            c_DONE:  if (out_ready) state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        quo_d = quo_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        dbz_d = dbz_q;
        case (state_q)
            c_IDLE: begin
                if (in_valid) begin
                    quo_d = dividend;
                    rem_d = '0;
                    dvs_d = divisor;
                    cnt_d = CNT_W'(WIDTH);
                    dbz_d = (divisor == '0);
                end
            end
            c_BUSY: begin
                // A zero divisor spends a single BUSY cycle forming its fixed result.
                if (dbz_q) begin
                    quo_d = '1;
                    rem_d = quo_q;
                    cnt_d = '0;
                end else begin
                    quo_d = {quo_q[WIDTH-2:0], ~w_borrow};
                    rem_d = w_borrow ? w_s[WIDTH-1:0] : w_t[WIDTH-1:0];
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        in_ready    = (state_q == c_IDLE);
        out_valid   = (state_q == c_DONE);
        quotient    = quo_q;
        remainder   = rem_q;
        div_by_zero = dbz_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_div_restoring.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_div_restoring
// Brief    : Self-checking bench for seq_div_restoring: directed vectors,
//            backpressure/reset corner cases and a randomized handshake sweep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_div_restoring;

    localparam int WIDTH = 8;
    localparam int N_RND = 2500;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
        int               lat;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
    } res_t;

    vec_t tbl[7];
    res_t exp_fifo[$];

    seq_div_restoring #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        res_t res;
        if (b == 0) begin
            res.q   = {WIDTH{1'b1}};
            res.r   = a;
            res.dbz = 1'b1;
        end else begin
            res.q   = a / b;
            res.r   = a % b;
            res.dbz = 1'b0;
        end
        return res;
    endfunction

    // One division with out_ready held high, checking latency, result and re-arm.
    task automatic run_one(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                           input logic edbz, input int elat);
        int lat;
        out_ready = 1'b1;
        chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        step();
        in_valid = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'(elat));
        chk({name, "_q"}, 32'(quotient), 32'(eq));
        chk({name, "_r"}, 32'(remainder), 32'(er));
        chk({name, "_dbz"}, 32'(div_by_zero), 32'(edbz));
        step();
        chk({name, "_rearm_ready"}, 32'(in_ready), 32'd1);
        chk({name, "_rearm_valid"}, 32'(out_valid), 32'd0);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        chk({name, "_valid_seen"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        tbl[0] = '{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4,   dbz: 1'b0, lat: 8};
        tbl[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,   dbz: 1'b0, lat: 8};
        tbl[2] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,   dbz: 1'b0, lat: 8};
        tbl[3] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,   dbz: 1'b0, lat: 8};
        tbl[4] = '{a: 8'd0,   b: 8'd3,   q: 8'd0,   r: 8'd0,   dbz: 1'b0, lat: 8};
        tbl[5] = '{a: 8'd100, b: 8'd0,   q: 8'd255, r: 8'd100, dbz: 1'b1, lat: 1};
        tbl[6] = '{a: 8'd9,   b: 8'd3,   q: 8'd3,   r: 8'd0,   dbz: 1'b0, lat: 8};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        step();
        step();
        rst = 1'b0;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_q", 32'(quotient), 32'd0);
        chk("reset_r", 32'(remainder), 32'd0);
        chk("reset_dbz", 32'(div_by_zero), 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_one($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r,
                    tbl[i].dbz, tbl[i].lat);
        end

        // Backpressure: result held while pending operands wait for IDLE.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        dividend  = 8'd77;
        divisor   = 8'd10;
        step();
        in_valid = 1'b0;
        wait_valid("bp");
        in_valid = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_q", 32'(quotient), 32'd7);
            chk("bp_hold_r", 32'(remainder), 32'd7);
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("bp_after_hs_ready", 32'(in_ready), 32'd1);
        chk("bp_after_hs_valid", 32'(out_valid), 32'd0);
        step();
        in_valid = 1'b0;
        wait_valid("bp2");
        chk("bp2_q", 32'(quotient), 32'd10);
        chk("bp2_r", 32'(remainder), 32'd0);
        step();

        // Reset during iteration 4 aborts the operation.
        in_valid = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd7;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_q", 32'(quotient), 32'd0);
        chk("abort_r", 32'(remainder), 32'd0);
        chk("abort_dbz", 32'(div_by_zero), 32'd0);
        run_one("post_abort", 8'd13, 8'd4, 8'd3, 8'd1, 1'b0, 8);

        // Random sweep with independent source and sink stalls.
        fork
            begin : drv
                bit timed_out;
                timed_out = 1'b0;
                for (int i = 0; i < N_RND && !timed_out; i++) begin
                    int idle;
                    int w;
                    int sel;
                    logic [WIDTH-1:0] a;
                    logic [WIDTH-1:0] b;
                    idle = $urandom_range(0, 2);
                    in_valid = 1'b0;
                    repeat (idle) step();
                    a   = 8'($urandom_range(0, 255));
                    sel = $urandom_range(0, 9);
                    if (sel == 0)     b = '0;
                    else if (sel < 4) b = 8'($urandom_range(1, 15));
                    else              b = 8'($urandom_range(1, 255));
                    in_valid = 1'b1;
                    dividend = a;
                    divisor  = b;
                    w = 0;
                    while (!in_ready && !timed_out) begin
                        step();
                        w++;
                        if (w > 100) timed_out = 1'b1;
                    end
                    if (timed_out) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL rnd_accept_timeout: op %0d not accepted", i);
                    end else begin
                        exp_fifo.push_back(model(a, b));
                        step();
                        in_valid = 1'b0;
                        dividend = 8'($urandom);
                        divisor  = 8'($urandom);
                    end
                end
                in_valid = 1'b0;
            end
            begin : mon
                int got;
                int cyc;
                got = 0;
                cyc = 0;
                while (got < N_RND && cyc < 60000) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid && out_ready) begin
                        if (exp_fifo.size() == 0) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL rnd_spurious: result q=%0d r=%0d with none expected",
                                     quotient, remainder);
                        end else begin
                            res_t e;
                            e = exp_fifo.pop_front();
                            chk("rnd_q", 32'(quotient), 32'(e.q));
                            chk("rnd_r", 32'(remainder), 32'(e.r));
                            chk("rnd_dbz", 32'(div_by_zero), 32'(e.dbz));
                        end
                        got++;
                    end
                    step();
                    cyc++;
                end
                chk("rnd_result_count", 32'(got), 32'(N_RND));
            end
        join
        chk("rnd_leftover", 32'(exp_fifo.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
